// File: rtl/lstm_dot_accum_pkg.sv
// lstm_dot_accum_pkg
// Shared definitions for the LSTM dot-product accumulator:
//   `CNN_XLEN   default product/result width (shared with the multiplier)
//   `AUG_FCT_B  guard bits added on top of DATA_WID + $clog2(VEC_LEN)
//   lstm_acc_state_e  FSM state encodings
//   lstm_acc_wid()    default internal accumulator width
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

`ifndef AUG_FCT_B
`define AUG_FCT_B 2
`endif

package lstm_dot_accum_pkg;

  typedef enum logic [1:0] {
    LSTM_ACC_IDLE  = 2'd0,
    LSTM_ACC_ACCUM = 2'd1,
    LSTM_ACC_HOLD  = 2'd2
  } lstm_acc_state_e;

  localparam int unsigned LSTM_ACC_AUG_B = `AUG_FCT_B;

  // VEC_LEN products plus the bias can never overflow this width.
  function automatic int unsigned lstm_acc_wid(input int unsigned data_wid,
                                               input int unsigned vec_len);
    return data_wid + $clog2(vec_len) + LSTM_ACC_AUG_B;
  endfunction

endpackage

// File: rtl/lstm_dot_accum_narrow.sv
// lstm_acc_narrow
// Combinational narrowing of the ACC_WID-bit signed sum back to DATA_WID.
// Optional feature macro: LSTM_ACC_SAT_EN
//   defined   : clamp to the signed DATA_WID range, sat_o flags a clamp
//   undefined : keep the low DATA_WID bits (two's-complement wrap), sat_o = 0
// Ports:
//   acc_i   in  ACC_WID   signed accumulator value
//   data_o  out DATA_WID  narrowed result
//   sat_o   out 1         clamping occurred
module lstm_acc_narrow #(
  parameter int unsigned DATA_WID = 16,
  parameter int unsigned ACC_WID  = 20
) (
  input  logic [ACC_WID-1:0]  acc_i,
  output logic [DATA_WID-1:0] data_o,
  output logic                sat_o
);

`ifdef LSTM_ACC_SAT_EN
  // The value fits when the sign bit of the narrow result and every bit
  // above it agree.
  logic [ACC_WID-DATA_WID:0] hi;
  logic                      fits;

  assign hi   = acc_i[ACC_WID-1:DATA_WID-1];
  assign fits = (&hi) || (~|hi);

  always_comb begin
    data_o = acc_i[DATA_WID-1:0];
    sat_o  = 1'b0;
    if (!fits) begin
      sat_o  = 1'b1;
      data_o = acc_i[ACC_WID-1] ? {1'b1, {(DATA_WID-1){1'b0}}}
                                : {1'b0, {(DATA_WID-1){1'b1}}};
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^acc_i[ACC_WID-1:DATA_WID];
  assign data_o    = acc_i[DATA_WID-1:0];
  assign sat_o     = 1'b0;
`endif

endmodule

// File: rtl/lstm_dot_accum.sv
// lstm_dot_accum
// Streaming signed accumulator behind the LSTM multiplier: bias + up to
// VEC_LEN pre-scaled products, narrowed to DATA_WID and handed to the
// activation stage over valid/ready.
// Optional feature macro: LSTM_ACC_SAT_EN (saturating narrowing, see
// lstm_acc_narrow).
// Ports:
//   clock        in   single clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   in_valid     in   product beat valid
//   in_ready     out  beat can be accepted (low while a result is held)
//   in_data      in   signed product, DATA_WID
//   in_last      in   last beat of the vector
//   bias         in   signed bias, sampled on the first beat only
//   out_valid    out  result valid
//   out_ready    in   downstream accepts result
//   out_data     out  signed narrowed sum, DATA_WID
//   out_len_err  out  vector cut at VEC_LEN beats without in_last
//   out_sat      out  narrowing clamped (0 when saturation not built)
//
// state          | meaning
// LSTM_ACC_IDLE  | no beat of the current vector seen yet
// LSTM_ACC_ACCUM | at least one beat accepted, summing
// LSTM_ACC_HOLD  | result registered and offered downstream
module lstm_dot_accum
  import lstm_dot_accum_pkg::*;
#(
  parameter int unsigned DATA_WID = `CNN_XLEN,
  parameter int unsigned VEC_LEN  = 64,
  parameter int unsigned ACC_WID  = lstm_acc_wid(DATA_WID, VEC_LEN)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_WID-1:0] in_data,
  input  logic                in_last,
  input  logic [DATA_WID-1:0] bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] out_data,
  output logic                out_len_err,
  output logic                out_sat
);

  localparam int unsigned CNT_WID = $clog2(VEC_LEN + 1);

  lstm_acc_state_e     state_q, state_d;
  logic [ACC_WID-1:0]  acc_q, acc_d;
  logic [CNT_WID-1:0]  cnt_q, cnt_d;
  logic [DATA_WID-1:0] out_data_q, out_data_d;
  logic                out_len_err_q, out_len_err_d;
  logic                out_sat_q, out_sat_d;

  logic                accept;
  logic                go_hold;
  logic [ACC_WID-1:0]  data_ext;
  logic [ACC_WID-1:0]  bias_ext;
  logic [DATA_WID-1:0] narrow_data;
  logic                narrow_sat;

  assign in_ready    = (state_q != LSTM_ACC_HOLD);
  assign out_valid   = (state_q == LSTM_ACC_HOLD);
  assign out_data    = out_data_q;
  assign out_len_err = out_len_err_q;
  assign out_sat     = out_sat_q;

  assign accept   = in_valid && in_ready;
  assign data_ext = {{(ACC_WID-DATA_WID){in_data[DATA_WID-1]}}, in_data};
  assign bias_ext = {{(ACC_WID-DATA_WID){bias[DATA_WID-1]}}, bias};

  // Narrowing works on the next accumulator value so the result can be
  // registered on the same edge that takes the final beat.
  lstm_acc_narrow #(
    .DATA_WID (DATA_WID),
    .ACC_WID  (ACC_WID)
  ) u_narrow (
    .acc_i  (acc_d),
    .data_o (narrow_data),
    .sat_o  (narrow_sat)
  );

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    out_len_err_d = out_len_err_q;
    go_hold       = 1'b0;

    unique case (state_q)
      LSTM_ACC_IDLE: begin
        if (accept) begin
          acc_d = bias_ext + data_ext;
          cnt_d = CNT_WID'(1);
          if (in_last) begin
            state_d       = LSTM_ACC_HOLD;
            go_hold       = 1'b1;
            out_len_err_d = 1'b0;
          end else begin
            state_d = LSTM_ACC_ACCUM;
          end
        end
      end
      LSTM_ACC_ACCUM: begin
        if (accept) begin
          acc_d = acc_q + data_ext;
          cnt_d = cnt_q + CNT_WID'(1);
          // cnt_q == VEC_LEN-1 means this beat is number VEC_LEN.
          if (in_last || (cnt_q == CNT_WID'(VEC_LEN - 1))) begin
            state_d       = LSTM_ACC_HOLD;
            go_hold       = 1'b1;
            out_len_err_d = !in_last;
          end
        end
      end
      LSTM_ACC_HOLD: begin
        if (out_ready) begin
          state_d = LSTM_ACC_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LSTM_ACC_IDLE;
        cnt_d   = '0;
      end
    endcase

    out_data_d = go_hold ? narrow_data : out_data_q;
    out_sat_d  = go_hold ? narrow_sat  : out_sat_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= LSTM_ACC_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_len_err_q <= 1'b0;
      out_sat_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_len_err_q <= out_len_err_d;
      out_sat_q     <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_lstm_dot_accum.sv
module tb_lstm_dot_accum;

  localparam int DW    = 16;
  localparam int VL    = 4;
  localparam int NVEC  = 1000;
  localparam int LIMIT = 60000;

`ifdef LSTM_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
    logic          s;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [DW-1:0] bias;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_len_err;
  logic          out_sat;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  exp_t expq[$];

  lstm_dot_accum #(.DATA_WID(DW), .VEC_LEN(VL)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .bias        (bias),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_len_err (out_len_err),
    .out_sat     (out_sat)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference: exact integer sum of the vector, then narrowed by the
  // configured rule.
  function automatic exp_t model(input int sum, input bit err);
    exp_t r;
    r.e = err;
    if (SAT && sum > 32767) begin
      r.d = 16'h7FFF; r.s = 1'b1;
    end else if (SAT && sum < -32768) begin
      r.d = 16'h8000; r.s = 1'b1;
    end else begin
      r.d = sum[15:0]; r.s = 1'b0;
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic drive_beat(input logic [DW-1:0] d, input logic l, input logic [DW-1:0] b);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l; bias = b;
    @(negedge clock);
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL beat_accept: in_ready=%b expected 1 within 20 cycles", in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic take_result(input string name, input logic [DW-1:0] ed,
                             input logic ee, input logic es);
    int n = 0;
    out_ready = 1'b1;
    @(negedge clock);
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_valid: out_valid=0 expected 1 within 20 cycles", name);
    end
    checks++;
    if (out_data !== ed) begin
      errors++;
      $display("FAIL %s_data: out_data=%h expected %h", name, out_data, ed);
    end
    checks++;
    if (out_len_err !== ee) begin
      errors++;
      $display("FAIL %s_len_err: out_len_err=%b expected %b", name, out_len_err, ee);
    end
    checks++;
    if (out_sat !== es) begin
      errors++;
      $display("FAIL %s_sat: out_sat=%b expected %b", name, out_sat, es);
    end
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b expected 0 after handshake", name, out_valid);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
        out_len_err !== 1'b0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL %s: rdy=%b vld=%b data=%h err=%b sat=%b expected 1 0 0000 0 0",
               name, in_ready, out_valid, out_data, out_len_err, out_sat);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; bias = '0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset_state");
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_beat(16'h0001, 1'b0, 16'h0010);
    drive_beat(16'h0002, 1'b0, 16'hBEEF);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: out_valid=%b expected 0", out_valid);
    end
    drive_beat(16'h0003, 1'b1, 16'hBEEF);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h0016 || out_len_err !== 1'b0 || out_sat !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: vld=%b data=%h err=%b sat=%b expected 1 0016 0 0",
               out_valid, out_data, out_len_err, out_sat);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_one_cycle_hold: vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_forced_end();
    for (int i = 0; i < VL; i++) drive_beat(16'h7000, 1'b0, 16'h7000);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL forced_end_hold: vld=%b rdy=%b expected 1 0", out_valid, in_ready);
    end
    take_result("forced_end", SAT ? 16'h7FFF : 16'h3000, 1'b1, SAT);
  endtask

  task automatic test_neg_sat();
    drive_beat(16'h8000, 1'b0, 16'h8000);
    drive_beat(16'h8000, 1'b1, 16'h0000);
    take_result("neg_sat", 16'h8000, 1'b0, SAT);
  endtask

  task automatic test_hold_stall();
    drive_beat(16'hFFFF, 1'b1, 16'h0001);
    in_valid = 1'b1; in_data = 16'h0005; in_last = 1'b1; bias = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h0000) begin
        errors++;
        $display("FAIL hold_stall: rdy=%b vld=%b data=%h expected 0 1 0000",
                 in_ready, out_valid, out_data);
      end
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    @(posedge clock); #1;
    in_valid = 1'b0;
    take_result("hold_next", 16'h0007, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    drive_beat(16'h0100, 1'b0, 16'h0200);
    drive_beat(16'h0100, 1'b0, 16'h0000);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset_mid_vector");
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    drive_beat(16'h0003, 1'b1, 16'h0020);
    take_result("after_reset", 16'h0023, 1'b0, 1'b0);
    drive_beat(16'h0004, 1'b1, 16'h0004);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset_in_hold");
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    int   vec_done = 0;
    int   got = 0;
    int   bcnt = 0;
    int   sum = 0;
    bit   prev_hold = 1'b0;
    exp_t held, r, e;
    fork
      begin
        while (vec_done < NVEC && cyc < LIMIT) begin
          @(posedge clock); #1;
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
          end else begin
            in_valid = 1'b1;
            in_data  = ($urandom_range(0, 3) == 0) ? DW'($urandom)
                                                    : DW'($urandom_range(0, 127) - 64);
            in_last  = ($urandom_range(0, 2) == 0);
            bias     = ($urandom_range(0, 3) == 0) ? DW'($urandom)
                                                    : DW'($urandom_range(0, 127) - 64);
          end
          @(negedge clock);
          if (in_valid && in_ready) begin
            if (bcnt == 0) sum = int'($signed(bias));
            sum += int'($signed(in_data));
            bcnt++;
            if (in_last || bcnt == VL) begin
              expq.push_back(model(sum, !in_last));
              bcnt = 0;
              vec_done++;
            end
          end
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
      end
      begin
        while (got < NVEC && cyc < LIMIT) begin
          @(posedge clock); #1;
          out_ready = ($urandom_range(0, 2) != 0);
          @(negedge clock);
          if (prev_hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held.d || out_len_err !== held.e || out_sat !== held.s) begin
              errors++;
              $display("FAIL rand_stable: vld=%b data=%h err=%b sat=%b expected 1 %h %b %b",
                       out_valid, out_data, out_len_err, out_sat, held.d, held.e, held.s);
            end
          end
          if (out_valid && out_ready) begin
            r = '{d: out_data, e: out_len_err, s: out_sat};
            checks++;
            if (expq.size() == 0) begin
              errors++;
              $display("FAIL rand_extra: result %h with no expected vector", out_data);
            end else begin
              e = expq.pop_front();
              if (r !== e) begin
                errors++;
                $display("FAIL rand_result %0d: data=%h err=%b sat=%b expected %h %b %b",
                         got, r.d, r.e, r.s, e.d, e.e, e.s);
              end
            end
            got++;
            prev_hold = 1'b0;
          end else if (out_valid) begin
            prev_hold = 1'b1;
            held = '{d: out_data, e: out_len_err, s: out_sat};
          end else begin
            prev_hold = 1'b0;
          end
        end
        @(posedge clock); #1;
        out_ready = 1'b0;
      end
    join
    checks++;
    if (got != NVEC || expq.size() != 0) begin
      errors++;
      $display("FAIL rand_count: results=%0d pending=%0d expected %0d and 0",
               got, expq.size(), NVEC);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forced_end();
    test_neg_sat();
    test_hold_stall();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lstm_dot_accum.md
# lstm_dot_accum

Streaming signed fixed-point accumulator placed directly downstream of the LSTM single multiplier. Consumes one already-rescaled product per beat (DATA_WID bits, same Q-format as the multiplier output), adds a per-vector bias, and sums up to VEC_LEN products into one gate pre-activation value. The result is narrowed back to DATA_WID and presented to the activation stage over a valid/ready handshake.

## Interface
- DATA_WID, `CNN_XLEN: width of products, bias and result; signed fixed point, same format as multiplier output.
- VEC_LEN, 64: maximum beats per vector; must be ≥ 2.
- ACC_WID, DATA_WID+$clog2(VEC_LEN)+2: internal accumulator width. Wide enough that the accumulator never wraps.
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_WID  signed product from multiplier.
- in_last  in  1  marks the final beat of the vector.
- bias  in  DATA_WID  signed bias; sampled only on the first beat of a vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_WID  signed narrowed sum.
- out_len_err  out  1  vector was cut at VEC_LEN beats without in_last; qualified by out_valid.
- out_sat  out  1  narrowing clamped; qualified by out_valid; constant 0 when saturation is compiled out.

## Operation
- States: IDLE (no beat of the current vector seen), ACCUM (≥1 beat accepted), HOLD (result held for output).
- Beat accepted when in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- IDLE + accept: acc ← sext(bias) + sext(in_data); cnt ← 1; → ACCUM, or → HOLD if in_last.
- ACCUM + accept: acc ← acc + sext(in_data); cnt ← cnt+1; → HOLD if in_last or cnt == VEC_LEN-1.
- Forced end: beat number VEC_LEN accepted with in_last=0 → HOLD and out_len_err=1. in_last on that beat → out_len_err=0.
- Single-beat vector (in_last on first beat) is legal: result = bias + in_data.
- HOLD: out_valid=1; out_data, out_sat, out_len_err stable until out_ready. out_valid && out_ready → IDLE; cnt ← 0.
- No accept in HOLD; upstream stalls (in_ready=0) regardless of in_valid.
- Narrowing: sum = acc (ACC_WID signed). Output is the low DATA_WID bits, or the clamped value per Configuration. No further rescale; products arrive pre-scaled.
- Beats with in_valid=0 do not change acc or cnt in any state.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_len_err=0, out_sat=0, state=IDLE, acc=0, cnt=0.
- Latency: out_valid rises on the cycle after the last beat is accepted; out_data is registered.
- Throughput: one beat per cycle; minimum N+1 cycles per N-beat vector when out_ready=1 (HOLD always lasts ≥1 cycle; no same-cycle IDLE bypass).
- out_ready asserted before out_valid has no effect; out_valid never drops without handshake.
- Reset asserted mid-vector or in HOLD: immediate return to reset values; partial sum discarded.

## Configuration
- LSTM_ACC_SAT_EN defined: out_data = clamp(sum, −2^(DATA_WID−1), 2^(DATA_WID−1)−1); out_sat=1 when clamping occurred.
- Undefined: out_data = sum[DATA_WID-1:0] (two's-complement wrap); out_sat tied to 0.

## Structure
- Shared header/package: `CNN_XLEN, `AUG_FCT_B, state encodings (LSTM_ACC_IDLE/ACCUM/HOLD), and the default ACC_WID expression.
- One sub-module: lstm_acc_narrow (combinational ACC_WID→DATA_WID clamp/truncate plus sat flag), selected by LSTM_ACC_SAT_EN.

## Test plan
- DATA_WID=16, VEC_LEN=4, bias=0x0010, beats 0x0001,0x0002,0x0003, in_last on 3rd → out_data=0x0016, out_len_err=0, out_sat=0, out_valid one cycle after 3rd accept.
- Beats 0x7000 ×4, bias=0x7000, no in_last → forced end after 4th beat, out_len_err=1; SAT_EN: out_data=0x7FFF, out_sat=1; without: out_data=0x3000.
- Beats 0x8000 ×2, bias=0x8000, in_last on 2nd, SAT_EN → out_data=0x8000, out_sat=1.
- Single beat 0xFFFF with in_last, bias=0x0001 → out_data=0x0000; then out_ready held low 5 cycles → in_ready=0, out_data stable, next vector's in_valid ignored until handshake.
- Random in_valid gaps and out_ready back-pressure over 1000 vectors → results match reference model; no beat lost or duplicated.
- reset_n pulsed low after 2 beats → outputs at reset values asynchronously; next vector starts fresh from bias.
